// File: rtl/hack_mem_arbiter_if.sv
// Requester, RAM and status signals shared between the Hack memory arbiter and its environment.
// The slave modport is the arbiter's view; master is the CPU/DMA/RAM side.
interface hack_mem_arbiter_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 15
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic              cpu_stall;
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              owner_dma;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  ram_rdata,
      output cpu_ack, cpu_stall, dma_ack, rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      output owner_dma, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output ram_rdata,
      input  cpu_ack, cpu_stall, dma_ack, rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      input  owner_dma, busy
   );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Two-requester arbiter for the Hack data RAM: CPU has priority, a starvation counter forces
// the DMA through after STARVE_LIMIT consecutive CPU wins over a pending DMA request.
module hack_mem_arbiter #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input logic               clk,
   input logic               reset,
   hack_mem_arbiter_if.slave bus_io
);
   localparam int unsigned StW      = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned WaitLoad = (RD_LAT > 2) ? RD_LAT - 2 : 0;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

   state_e            state_q, state_d;
   logic              owner_dma_q, owner_dma_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [StW-1:0]    starve_q, starve_d;
   logic [1:0]        wait_q, wait_d;
   logic              starved;
   logic              grant_dma;
   logic              cpu_ack;

   assign starved = (starve_q == StW'(STARVE_LIMIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_dma_q <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         starve_q    <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         owner_dma_q <= owner_dma_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         starve_q    <= starve_d;
         wait_q      <= wait_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_dma_d = owner_dma_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      starve_d    = starve_q;
      wait_d      = wait_q;
      grant_dma   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_io.cpu_req || bus_io.dma_req) begin
               grant_dma   = bus_io.dma_req & (~bus_io.cpu_req | starved);
               owner_dma_d = grant_dma;
               ram_we_d    = grant_dma ? bus_io.dma_we    : bus_io.cpu_we;
               ram_addr_d  = grant_dma ? bus_io.dma_addr  : bus_io.cpu_addr;
               ram_wdata_d = grant_dma ? bus_io.dma_wdata : bus_io.cpu_wdata;
               // Only a CPU win over a waiting DMA counts toward starvation.
               if (grant_dma) begin
                  starve_d = '0;
               end else if (bus_io.dma_req && !starved) begin
                  starve_d = starve_q + 1'b1;
               end
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (RD_LAT > 1) begin
               state_d = StWait;
               wait_d  = 2'(WaitLoad);
            end else begin
               state_d = StAck;
            end
         end
         StWait: begin
            if (wait_q == '0) begin
               state_d = StAck;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         StAck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign cpu_ack          = (state_q == StAck) & ~owner_dma_q;
   assign bus_io.cpu_ack   = cpu_ack;
   assign bus_io.dma_ack   = (state_q == StAck) & owner_dma_q;
   assign bus_io.cpu_stall = bus_io.cpu_req & ~cpu_ack;
   assign bus_io.rdata     = bus_io.ram_rdata;
   assign bus_io.ram_en    = (state_q == StIssue);
   assign bus_io.ram_we    = ram_we_q;
   assign bus_io.ram_addr  = ram_addr_q;
   assign bus_io.ram_wdata = ram_wdata_q;
   assign bus_io.owner_dma = owner_dma_q;
   assign bus_io.busy      = (state_q != StIdle);
endmodule
